// File: rtl/dbuffer_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dbuffer_req_arbiter_pkg
// Shared definitions for the data-buffer request arbiter.
// The package holds the owner id encoding, the request field widths and the
// control part of the issue-stage record. The issue address and write data
// take their widths from the top-level parameters, so they are kept as
// separate registers next to this record.
// -----------------------------------------------------------------------------
package dbuffer_req_arbiter_pkg;

    localparam int FUNC3_W = 3;
    localparam int RD_W    = 5;

    // Requester identity. This is also the 1-bit payload of the load-owner FIFO.
    typedef enum logic {
        REQ_LSU = 1'b0,
        REQ_DBG = 1'b1
    } owner_e;

    // Issue-stage control fields. Field order: rd, func3, load, store, owner.
    // The address and write data sit beside this record in the top level.
    typedef struct packed {
        logic [RD_W-1:0]    rd;
        logic [FUNC3_W-1:0] func3;
        logic               load;
        logic               store;
        owner_e             owner;
    } issue_ctrl_t;

    // Round-robin helper: returns the requester that is not 'o'.
    function automatic owner_e other_owner(input owner_e o);
        return (o == REQ_LSU) ? REQ_DBG : REQ_LSU;
    endfunction

endpackage

// File: rtl/dbuffer_tag_fifo.sv
// -----------------------------------------------------------------------------
// dbuffer_tag_fifo
// In-order FIFO of 1-bit owner ids. There is one entry per load that has been
// handed to the data buffer and has not yet been answered.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   i_push        write i_push_data at the tail
//   i_push_data   owner id to store
//   i_pop         remove the head entry (ignored while empty)
//   o_pop_data    current head entry
//   o_count       number of stored entries (0..DEPTH)
//   o_empty       no entries stored
//   o_full        DEPTH entries stored
// A push and a pop in the same cycle are both accepted, even while full.
// -----------------------------------------------------------------------------
module dbuffer_tag_fifo #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_push_data,
    input  logic             i_pop,
    output logic             o_pop_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    // When the FIFO is full, a pop in the same cycle frees the slot that the
    // push overwrites at the clock edge. The head is read combinationally
    // before that edge.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // NOTE: the storage is deliberately left without reset. The pointers and the
    // count define which entries are valid, so clearing the array would only
    // add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments, so
    // every register samples values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // The pointers wrap naturally because DEPTH is a power of two.
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dbuffer_req_arbiter.sv
// -----------------------------------------------------------------------------
// dbuffer_req_arbiter
// Shares the single load/store enqueue port of the data buffer between the
// core LSU (req0) and the debug/DMA port (req1).
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   reqN_*            requester N: valid/ready handshake, load/store, func3,
//                     rd, addr and wdata
//   db_*  (out)       registered issue stage driving the buffer enqueue port
//   db_full           buffer backpressure; the issue stage holds while set
//   db_addr_err       buffer rejects the presented request (address error)
//   db_rsp_*          in-order load responses from the buffer
//   rspN_*            load responses routed back to requester N
//   errN              one-cycle pulse when requester N's request was rejected
// -----------------------------------------------------------------------------
module dbuffer_req_arbiter
    import dbuffer_req_arbiter_pkg::*;
#(
    parameter int TAG_DEPTH = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic               req0_load,
    input  logic               req0_store,
    input  logic [FUNC3_W-1:0] req0_func3,
    input  logic [RD_W-1:0]    req0_rd,
    input  logic [ADDR_W-1:0]  req0_addr,
    input  logic [DATA_W-1:0]  req0_wdata,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic               req1_load,
    input  logic               req1_store,
    input  logic [FUNC3_W-1:0] req1_func3,
    input  logic [RD_W-1:0]    req1_rd,
    input  logic [ADDR_W-1:0]  req1_addr,
    input  logic [DATA_W-1:0]  req1_wdata,
    output logic               db_load,
    output logic               db_store,
    output logic [FUNC3_W-1:0] db_func3,
    output logic [RD_W-1:0]    db_rd,
    output logic [ADDR_W-1:0]  db_addr,
    output logic [DATA_W-1:0]  db_wdata,
    input  logic               db_full,
    input  logic               db_addr_err,
    input  logic               db_rsp_valid,
    input  logic [DATA_W-1:0]  db_rsp_data,
    input  logic [RD_W-1:0]    db_rsp_rd,
    output logic               rsp0_valid,
    output logic [DATA_W-1:0]  rsp0_data,
    output logic [RD_W-1:0]    rsp0_rd,
    output logic               rsp1_valid,
    output logic [DATA_W-1:0]  rsp1_data,
    output logic [RD_W-1:0]    rsp1_rd,
    output logic               err0,
    output logic               err1
);

    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;
    localparam int OUT_W = CNT_W + 1;

    // Issue stage and arbitration state
    logic              r_iss_valid;
    issue_ctrl_t       r_iss;
    logic [ADDR_W-1:0] r_iss_addr;
    logic [DATA_W-1:0] r_iss_wdata;
    owner_e            r_prio;

    // Response and error stage
    logic              r_rsp0_valid;
    logic              r_rsp1_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic [RD_W-1:0]   r_rsp_rd;
    logic              r_err0;
    logic              r_err1;

    // Tag FIFO interface
    logic [CNT_W-1:0]  w_tag_count;
    logic              w_tag_empty;
    logic              w_tag_full;
    logic              w_tag_head;
    owner_e            w_head_owner;

    logic              w_drain;
    logic              w_issue_free;
    logic              w_pop;
    logic              w_push;
    owner_e            w_winner;
    logic              w_win_load;
    logic              w_win_store;
    issue_ctrl_t       w_req_ctrl;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_wdata;
    logic [OUT_W-1:0]  w_outstanding;
    logic              w_load_ok;
    logic              w_grant;
    logic              w_capture;

    // An address error also drains the stage: the buffer has made its
    // decision, so the request is dropped instead of being held.
    assign w_drain      = r_iss_valid & (~db_full | db_addr_err);
    assign w_issue_free = ~r_iss_valid | w_drain;
    assign w_pop        = db_rsp_valid & ~w_tag_empty;
    assign w_push       = w_drain & ~db_addr_err & r_iss.load & (~w_tag_full | w_pop);
    assign w_head_owner = owner_e'(w_tag_head);

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_winner = REQ_LSU;
        if (req0_valid && req1_valid) w_winner = r_prio;
        else if (req1_valid)          w_winner = REQ_DBG;
    end

    always_comb begin
        w_win_load  = req0_load;
        w_win_store = req0_store;
        w_req_addr  = req0_addr;
        w_req_wdata = req0_wdata;
        w_req_ctrl  = '{rd: req0_rd, func3: req0_func3, load: 1'b0, store: 1'b0, owner: REQ_LSU};
        if (w_winner == REQ_DBG) begin
            w_win_load  = req1_load;
            w_win_store = req1_store;
            w_req_addr  = req1_addr;
            w_req_wdata = req1_wdata;
            w_req_ctrl  = '{rd: req1_rd, func3: req1_func3, load: 1'b0, store: 1'b0, owner: REQ_DBG};
        end
        // A request with load and store both set is a load.
        w_req_ctrl.load  = w_win_load;
        w_req_ctrl.store = w_win_store & ~w_win_load;
    end

    // A load is admitted only if it cannot overflow the tag FIFO. The count
    // includes a load still sitting in the issue stage and credits a response
    // that is popped in this cycle.
    assign w_outstanding = OUT_W'(w_tag_count) + OUT_W'(r_iss_valid & r_iss.load) - OUT_W'(w_pop);
    assign w_load_ok     = ~w_win_load | (w_outstanding < OUT_W'(TAG_DEPTH));
    assign w_grant       = (req0_valid | req1_valid) & w_issue_free & w_load_ok;
    // A request with neither load nor store is granted but never issued.
    assign w_capture     = w_grant & (w_win_load | w_win_store);

    assign req0_ready = w_grant & (w_winner == REQ_LSU);
    assign req1_ready = w_grant & (w_winner == REQ_DBG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_valid <= 1'b0;
            r_iss       <= '0;
            r_iss_addr  <= '0;
            r_iss_wdata <= '0;
            r_prio      <= REQ_LSU;
        end else begin
            if (w_capture) begin
                r_iss_valid <= 1'b1;
                r_iss       <= w_req_ctrl;
                r_iss_addr  <= w_req_addr;
                r_iss_wdata <= w_req_wdata;
            end else if (w_drain) begin
                r_iss_valid <= 1'b0;
            end
            if (w_grant) r_prio <= other_owner(w_winner);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_rd     <= '0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
        end else begin
            r_rsp0_valid <= w_pop & (w_head_owner == REQ_LSU);
            r_rsp1_valid <= w_pop & (w_head_owner == REQ_DBG);
            if (w_pop) begin
                r_rsp_data <= db_rsp_data;
                r_rsp_rd   <= db_rsp_rd;
            end
            r_err0 <= w_drain & db_addr_err & (r_iss.owner == REQ_LSU);
            r_err1 <= w_drain & db_addr_err & (r_iss.owner == REQ_DBG);
        end
    end

    dbuffer_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (r_iss.owner),
        .i_pop       (w_pop),
        .o_pop_data  (w_tag_head),
        .o_count     (w_tag_count),
        .o_empty     (w_tag_empty),
        .o_full      (w_tag_full)
    );

    // The address, data, rd and func3 fields keep their last value while the
    // issue stage is empty. Only the strobes are qualified.
    assign db_load    = r_iss_valid & r_iss.load;
    assign db_store   = r_iss_valid & r_iss.store;
    assign db_func3   = r_iss.func3;
    assign db_rd      = r_iss.rd;
    assign db_addr    = r_iss_addr;
    assign db_wdata   = r_iss_wdata;

    // One shared response register; only the owner's valid is raised.
    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_data  = r_rsp_data;
    assign rsp0_rd    = r_rsp_rd;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_data  = r_rsp_data;
    assign rsp1_rd    = r_rsp_rd;
    assign err0       = r_err0;
    assign err1       = r_err1;

endmodule

// File: tb/tb_dbuffer_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dbuffer_req_arbiter
// Self-checking bench for dbuffer_req_arbiter. A transaction-level model
// (owner queue, issue slot, priority) predicts every output in every cycle.
// A vector table and short directed sequences add fixed expectations for the
// corner cases.
// -----------------------------------------------------------------------------
module tb_dbuffer_req_arbiter;

    localparam int TAG_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rq_valid [2];
    logic        rq_load  [2];
    logic        rq_store [2];
    logic [2:0]  rq_f3    [2];
    logic [4:0]  rq_rd    [2];
    logic [31:0] rq_addr  [2];
    logic [31:0] rq_wdata [2];
    logic        rdy      [2];
    logic        rsp_v    [2];
    logic [31:0] rsp_d    [2];
    logic [4:0]  rsp_rd   [2];
    logic        err      [2];
    logic        db_load, db_store, db_full, db_addr_err, db_rsp_valid;
    logic [2:0]  db_func3;
    logic [4:0]  db_rd, db_rsp_rd;
    logic [31:0] db_addr, db_wdata, db_rsp_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dbuffer_req_arbiter #(.TAG_DEPTH(TAG_DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(rq_valid[0]), .req0_ready(rdy[0]), .req0_load(rq_load[0]),
        .req0_store(rq_store[0]), .req0_func3(rq_f3[0]), .req0_rd(rq_rd[0]),
        .req0_addr(rq_addr[0]), .req0_wdata(rq_wdata[0]),
        .req1_valid(rq_valid[1]), .req1_ready(rdy[1]), .req1_load(rq_load[1]),
        .req1_store(rq_store[1]), .req1_func3(rq_f3[1]), .req1_rd(rq_rd[1]),
        .req1_addr(rq_addr[1]), .req1_wdata(rq_wdata[1]),
        .db_load(db_load), .db_store(db_store), .db_func3(db_func3), .db_rd(db_rd),
        .db_addr(db_addr), .db_wdata(db_wdata), .db_full(db_full),
        .db_addr_err(db_addr_err), .db_rsp_valid(db_rsp_valid),
        .db_rsp_data(db_rsp_data), .db_rsp_rd(db_rsp_rd),
        .rsp0_valid(rsp_v[0]), .rsp0_data(rsp_d[0]), .rsp0_rd(rsp_rd[0]),
        .rsp1_valid(rsp_v[1]), .rsp1_data(rsp_d[1]), .rsp1_rd(rsp_rd[1]),
        .err0(err[0]), .err1(err[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_iss_valid, m_iss_load, m_iss_store;
    int          m_iss_owner;
    logic [31:0] m_iss_addr, m_iss_wdata;
    logic [4:0]  m_iss_rd;
    logic [2:0]  m_iss_f3;
    int          m_tags[$];
    int          m_prio;
    bit          m_rsp_v[2];
    bit          m_err[2];
    logic [31:0] m_rsp_d;
    logic [4:0]  m_rsp_rd;
    bit          e_drain, e_pop, e_grant;
    int          e_win;

    task automatic model_reset();
        m_iss_valid = 0; m_iss_load = 0; m_iss_store = 0; m_iss_owner = 0;
        m_tags.delete(); m_prio = 0;
        m_rsp_v = '{0, 0}; m_err = '{0, 0};
    endtask

    task automatic model_eval();
        int outstanding;
        bit load_ok;
        e_drain = m_iss_valid && (!db_full || db_addr_err);
        e_pop   = db_rsp_valid && (m_tags.size() > 0);
        if (rq_valid[0] && rq_valid[1]) e_win = m_prio;
        else                            e_win = rq_valid[1] ? 1 : 0;
        outstanding = m_tags.size() + ((m_iss_valid && m_iss_load) ? 1 : 0) - (e_pop ? 1 : 0);
        load_ok = !rq_load[e_win] || (outstanding < TAG_DEPTH);
        e_grant = (rq_valid[0] || rq_valid[1]) && (!m_iss_valid || e_drain) && load_ok;
    endtask

    task automatic model_compare();
        for (int n = 0; n < 2; n++) begin
            check($sformatf("m_ready%0d", n), 64'(rdy[n]), 64'(e_grant && e_win == n));
            check($sformatf("m_rsp%0d_valid", n), 64'(rsp_v[n]), 64'(m_rsp_v[n]));
            check($sformatf("m_err%0d", n), 64'(err[n]), 64'(m_err[n]));
            if (m_rsp_v[n]) begin
                check($sformatf("m_rsp%0d_data", n), 64'(rsp_d[n]), 64'(m_rsp_d));
                check($sformatf("m_rsp%0d_rd", n), 64'(rsp_rd[n]), 64'(m_rsp_rd));
            end
        end
        check("m_db_load", 64'(db_load), 64'(m_iss_valid && m_iss_load));
        check("m_db_store", 64'(db_store), 64'(m_iss_valid && m_iss_store));
        if (m_iss_valid) begin
            check("m_db_addr", 64'(db_addr), 64'(m_iss_addr));
            check("m_db_wdata", 64'(db_wdata), 64'(m_iss_wdata));
            check("m_db_rd", 64'(db_rd), 64'(m_iss_rd));
            check("m_db_func3", 64'(db_func3), 64'(m_iss_f3));
        end
    endtask

    task automatic model_update();
        m_rsp_v = '{0, 0};
        m_err   = '{0, 0};
        if (e_pop) begin
            int head = m_tags.pop_front();
            m_rsp_v[head] = 1;
            m_rsp_d  = db_rsp_data;
            m_rsp_rd = db_rsp_rd;
        end
        if (e_drain) begin
            if (db_addr_err)     m_err[m_iss_owner] = 1;
            else if (m_iss_load) m_tags.push_back(m_iss_owner);
            m_iss_valid = 0;
        end
        if (e_grant) begin
            m_prio = 1 - e_win;
            if (rq_load[e_win] || rq_store[e_win]) begin
                m_iss_valid = 1;
                m_iss_owner = e_win;
                m_iss_load  = rq_load[e_win];
                m_iss_store = rq_store[e_win] && !rq_load[e_win];
                m_iss_addr  = rq_addr[e_win];
                m_iss_wdata = rq_wdata[e_win];
                m_iss_rd    = rq_rd[e_win];
                m_iss_f3    = rq_f3[e_win];
            end
        end
    endtask

    // Inputs are set at posedge+1. Outputs are compared at the negedge, and the
    // model advances at the posedge.
    task automatic tick();
        @(negedge clk);
        model_eval();
        model_compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        for (int n = 0; n < 2; n++) begin
            rq_valid[n] = 0; rq_load[n] = 0; rq_store[n] = 0; rq_f3[n] = 3'b010;
            rq_rd[n] = '0; rq_addr[n] = '0; rq_wdata[n] = '0;
        end
        db_full = 0; db_addr_err = 0; db_rsp_valid = 0; db_rsp_data = '0; db_rsp_rd = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        model_reset();
        #1;
        check("rst_db_load", 64'(db_load), 64'(0));
        check("rst_db_store", 64'(db_store), 64'(0));
        check("rst_db_addr", 64'(db_addr), 64'(0));
        for (int n = 0; n < 2; n++) begin
            check($sformatf("rst_ready%0d", n), 64'(rdy[n]), 64'(0));
            check($sformatf("rst_rsp%0d", n), 64'(rsp_v[n]), 64'(0));
            check($sformatf("rst_err%0d", n), 64'(err[n]), 64'(0));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input bit v, input bit ld, input bit st,
                           input logic [31:0] a, input logic [4:0] rd, input logic [31:0] wd);
        rq_valid[n] = v; rq_load[n] = ld; rq_store[n] = st;
        rq_addr[n] = a; rq_rd[n] = rd; rq_wdata[n] = wd; rq_f3[n] = 3'b010;
    endtask

    // ---------------- vector table: the two-requester load scenario ----------------
    typedef struct {
        logic        v0, l0;  logic [31:0] a0; logic [4:0] rd0;
        logic        v1, l1;  logic [31:0] a1; logic [4:0] rd1;
        logic        rv;      logic [31:0] rdat; logic [4:0] rrd;
        logic        e_rdy0, e_rdy1, e_dbl; logic [31:0] e_dba;
        logic        e_r0v, e_r1v; logic [31:0] e_rdat; logic [4:0] e_rrd;
    } vec_t;

    vec_t vecs[7];
    int   grants[2];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        #2;
        do_reset();

        vecs[0] = '{1'b1, 1'b1, 32'h10, 5'd5, 1'b1, 1'b1, 32'h20, 5'd6, 1'b0, 32'h0, 5'd0,
                    1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 5'd0};
        vecs[1] = '{1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 1'b1, 32'h20, 5'd6, 1'b0, 32'h0, 5'd0,
                    1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 5'd0};
        vecs[2] = '{1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0,
                    1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 5'd0};
        vecs[3] = '{1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 32'hAAAA, 5'd5,
                    1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 5'd0};
        vecs[4] = '{1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 32'hBBBB, 5'd6,
                    1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'hAAAA, 5'd5};
        vecs[5] = '{1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0,
                    1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'hBBBB, 5'd6};
        vecs[6] = '{1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0,
                    1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 5'd0};

        for (int i = 0; i < 7; i++) begin
            set_req(0, vecs[i].v0, vecs[i].l0, 1'b0, vecs[i].a0, vecs[i].rd0, 32'h0);
            set_req(1, vecs[i].v1, vecs[i].l1, 1'b0, vecs[i].a1, vecs[i].rd1, 32'h0);
            db_rsp_valid = vecs[i].rv; db_rsp_data = vecs[i].rdat; db_rsp_rd = vecs[i].rrd;
            #1;
            check($sformatf("vec%0d_ready0", i), 64'(rdy[0]), 64'(vecs[i].e_rdy0));
            check($sformatf("vec%0d_ready1", i), 64'(rdy[1]), 64'(vecs[i].e_rdy1));
            check($sformatf("vec%0d_db_load", i), 64'(db_load), 64'(vecs[i].e_dbl));
            if (vecs[i].e_dbl) check($sformatf("vec%0d_db_addr", i), 64'(db_addr), 64'(vecs[i].e_dba));
            check($sformatf("vec%0d_rsp0_valid", i), 64'(rsp_v[0]), 64'(vecs[i].e_r0v));
            check($sformatf("vec%0d_rsp1_valid", i), 64'(rsp_v[1]), 64'(vecs[i].e_r1v));
            if (vecs[i].e_r0v) begin
                check($sformatf("vec%0d_rsp0_data", i), 64'(rsp_d[0]), 64'(vecs[i].e_rdat));
                check($sformatf("vec%0d_rsp0_rd", i), 64'(rsp_rd[0]), 64'(vecs[i].e_rrd));
            end
            if (vecs[i].e_r1v) begin
                check($sformatf("vec%0d_rsp1_data", i), 64'(rsp_d[1]), 64'(vecs[i].e_rdat));
                check($sformatf("vec%0d_rsp1_rd", i), 64'(rsp_rd[1]), 64'(vecs[i].e_rrd));
            end
            tick();
        end

        // Both requesters hold stores for 8 cycles: grants alternate 0,1,0,1...
        do_reset();
        grants = '{0, 0};
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1'b1, 1'b0, 1'b1, 32'h100 + 32'(i), 5'd1, 32'(i));
            set_req(1, 1'b1, 1'b0, 1'b1, 32'h200 + 32'(i), 5'd2, 32'(i));
            #1;
            check($sformatf("alt%0d_ready0", i), 64'(rdy[0]), 64'(i % 2 == 0));
            check($sformatf("alt%0d_ready1", i), 64'(rdy[1]), 64'(i % 2 == 1));
            grants[0] += int'(rdy[0]);
            grants[1] += int'(rdy[1]);
            tick();
        end
        check("alt_grants0", 64'(grants[0]), 64'(4));
        check("alt_grants1", 64'(grants[1]), 64'(4));

        // Backpressure: a store is held stable for 3 cycles while db_full is high.
        do_reset();
        set_req(0, 1'b1, 1'b0, 1'b1, 32'h40, 5'd0, 32'h1234);
        #1; check("full_accept", 64'(rdy[0]), 64'(1)); tick();
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b1, 32'h80, 5'd0, 32'h5678);
        db_full = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("full%0d_store", i), 64'(db_store), 64'(1));
            check($sformatf("full%0d_addr", i), 64'(db_addr), 64'(32'h40));
            check($sformatf("full%0d_wdata", i), 64'(db_wdata), 64'(32'h1234));
            check($sformatf("full%0d_ready1", i), 64'(rdy[1]), 64'(0));
            tick();
        end
        db_full = 0;
        #1;
        check("full_drain_addr", 64'(db_addr), 64'(32'h40));
        check("full_drain_ready1", 64'(rdy[1]), 64'(1));
        tick();
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
        #1; check("full_next_addr", 64'(db_addr), 64'(32'h80)); tick();

        // Address error: a req1 load to 0x42 is dropped and err1 pulses once.
        do_reset();
        set_req(1, 1'b1, 1'b1, 1'b0, 32'h42, 5'd7, 32'h0);
        #1; check("aerr_accept", 64'(rdy[1]), 64'(1)); tick();
        set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
        db_addr_err = 1;
        #1;
        check("aerr_db_addr", 64'(db_addr), 64'(32'h42));
        check("aerr_db_func3", 64'(db_func3), 64'(3'b010));
        tick();
        db_addr_err = 0;
        #1;
        check("aerr_err1", 64'(err[1]), 64'(1));
        check("aerr_err0", 64'(err[0]), 64'(0));
        tick();
        db_rsp_valid = 1; db_rsp_data = 32'hDEAD;
        #1; check("aerr_err1_once", 64'(err[1]), 64'(0)); tick();
        db_rsp_valid = 0;
        #1; check("aerr_no_rsp1", 64'(rsp_v[1]), 64'(0)); tick();

        // Tag capacity: 4 loads accepted, the 5th is held until a response pops.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, 1'b1, 1'b0, 32'h100 + 32'(4 * i), 5'(i), 32'h0);
            #1; check($sformatf("cap_accept%0d", i), 64'(rdy[0]), 64'(1)); tick();
        end
        set_req(0, 1'b1, 1'b1, 1'b0, 32'h110, 5'd9, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1; check($sformatf("cap_hold%0d", i), 64'(rdy[0]), 64'(0)); tick();
        end
        db_rsp_valid = 1; db_rsp_data = 32'h55; db_rsp_rd = 5'd1;
        #1; check("cap_ready_on_pop", 64'(rdy[0]), 64'(1)); tick();
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
        db_rsp_valid = 0;
        #1;
        check("cap_5th_issued", 64'(db_load), 64'(1));
        check("cap_5th_addr", 64'(db_addr), 64'(32'h110));
        check("cap_rsp0_valid", 64'(rsp_v[0]), 64'(1));
        check("cap_rsp0_data", 64'(rsp_d[0]), 64'(32'h55));
        tick();

        // A response with the tag FIFO empty is ignored. Reset mid-stream
        // discards the pending loads.
        do_reset();
        db_rsp_valid = 1; db_rsp_data = 32'h77;
        #1; tick();
        db_rsp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * i), 5'd3, 32'h0);
            #1;
            if (i == 0) begin
                check("empty_rsp0", 64'(rsp_v[0]), 64'(0));
                check("empty_rsp1", 64'(rsp_v[1]), 64'(0));
            end
            check($sformatf("mid_accept%0d", i), 64'(rdy[0]), 64'(1));
            tick();
        end
        set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 32'h0);
        db_full = 1;
        #1; check("mid_pending_load", 64'(db_load), 64'(1));
        do_reset();
        db_rsp_valid = 1; db_rsp_data = 32'h99;
        #1; tick();
        db_rsp_valid = 0;
        #1;
        check("mid_rst_rsp0", 64'(rsp_v[0]), 64'(0));
        check("mid_rst_rsp1", 64'(rsp_v[1]), 64'(0));
        tick();

        // Randomised traffic checked by the model in every cycle.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int n = 0; n < 2; n++) begin
                rq_valid[n] = ($urandom_range(0, 9) < 6);
                rq_load[n]  = 1'($urandom_range(0, 1));
                rq_store[n] = 1'($urandom_range(0, 1));
                rq_f3[n]    = 3'($urandom_range(0, 7));
                rq_rd[n]    = 5'($urandom_range(0, 31));
                rq_addr[n]  = $urandom();
                rq_wdata[n] = $urandom();
            end
            db_full      = ($urandom_range(0, 3) == 0);
            db_addr_err  = ($urandom_range(0, 6) == 0);
            db_rsp_valid = ($urandom_range(0, 2) == 0);
            db_rsp_data  = $urandom();
            db_rsp_rd    = 5'($urandom_range(0, 31));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
